// File: rtl/score_display_pkg.sv
// display_pkg: shared definitions for the score display slice.
//   conv_state_t  - states of the sequential binary-to-BCD converter
//   SEG_BLANK     - all segments off (active-low)
//   SEG_DASH      - only segment g lit, used to flag overflow
//   seg_decode()  - BCD digit to active-low 7-segment pattern (g..a)
//   pow10_minus1()- largest value that fits in n decimal digits
package display_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } conv_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Active-low segments, bit 6 = g ... bit 0 = a. Codes 10-15 cannot come
  // out of the converter but are shown blank rather than as garbage.
  function automatic logic [6:0] seg_decode(logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  function automatic int pow10_minus1(int n);
    int p;
    p = 1;
    for (int i = 0; i < n; i++) begin
      p = p * 10;
    end
    return p - 1;
  endfunction

endpackage

// File: rtl/score_display_if.sv
// score_display_if: request/status bundle between the game-logic score
// counter (master) and the score display (slave).
//   value    - binary score, sampled when a load is accepted
//   load     - conversion request
//   busy     - conversion in progress
//   done     - one-cycle pulse when the new display value takes effect
//   overflow - last accepted value does not fit in the active digits
interface score_display_if #(
  parameter int BIN_WIDTH = 10
);

  logic [BIN_WIDTH-1:0] value;
  logic                 load;
  logic                 busy;
  logic                 done;
  logic                 overflow;

  modport master (
    output value,
    output load,
    input  busy,
    input  done,
    input  overflow
  );

  modport slave (
    input  value,
    input  load,
    output busy,
    output done,
    output overflow
  );

endinterface

// File: rtl/score_display_bin2bcd.sv
// bin2bcd_seq: multi-cycle shift-and-add-3 (double dabble) converter.
//   clk, rst_n - clock, synchronous active-low reset
//   start      - conversion request, accepted only when idle
//   bin        - binary input, captured on an accepted start
//   busy       - high in CONV and DONE
//   done       - registered one-cycle pulse, coincides with bcd update
//   bcd        - result register, 4 bits per digit, digit 0 in bits 3:0
module bin2bcd_seq
  import display_pkg::*;
#(
  parameter int BIN_WIDTH  = 10,
  parameter int NUM_DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [BIN_WIDTH-1:0]    bin,
  output logic                    busy,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] bcd
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BIN_WIDTH - 1);

  conv_state_t          state, state_next;
  logic [BIN_WIDTH-1:0] shift_reg;
  logic [BCD_W-1:0]     scratch;
  logic [BCD_W-1:0]     scratch_adj;
  logic [CNT_W-1:0]     bit_cnt;

  // Add-3 correction: any nibble >= 5 would become >= 10 after the
  // shift, so pre-add 3 to make the carry land in the next digit.
  always_comb begin
    scratch_adj = scratch;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (scratch[4*d +: 4] >= 4'd5) begin
        scratch_adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    case (state)
      IDLE:    if (start) state_next = CONV;
      CONV:    if (bit_cnt == LAST_BIT) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bits shifted out of the top of the scratch register are dropped;
  // the top level flags such values as overflow instead.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift_reg <= '0;
      scratch   <= '0;
      bit_cnt   <= '0;
      bcd       <= '0;
      done      <= 1'b0;
    end else begin
      state <= state_next;
      done  <= (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            shift_reg <= bin;
            scratch   <= '0;
            bit_cnt   <= '0;
          end
        end
        CONV: begin
          scratch   <= {scratch_adj[BCD_W-2:0], shift_reg[BIN_WIDTH-1]};
          shift_reg <= shift_reg << 1;
          bit_cnt   <= bit_cnt + 1'b1;
        end
        DONE: begin
          bcd <= scratch;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/score_display.sv
// score_display: converts a binary score to decimal and drives up to six
// active-low 7-segment digits with leading-zero blanking, overflow dashes
// and an optional blink.
//   clk, rst_n - clock, synchronous active-low reset
//   bus        - slave side of score_display_if (value/load in,
//                busy/done/overflow out)
//   blank_lz   - blank leading zeros (HEX0 never blanked)
//   blink_en   - blink all active digits
//   HEX0..HEX5 - active-low segments, bit 6 = g ... bit 0 = a
module score_display
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = 3,
  parameter int BIN_WIDTH    = 10,
  parameter int BLINK_CYCLES = 25_000_000
) (
  input  logic            clk,
  input  logic            rst_n,
  score_display_if.slave  bus,
  input  logic            blank_lz,
  input  logic            blink_en,
  output logic [6:0]      HEX0,
  output logic [6:0]      HEX1,
  output logic [6:0]      HEX2,
  output logic [6:0]      HEX3,
  output logic [6:0]      HEX4,
  output logic [6:0]      HEX5
);

  localparam logic [31:0] MAX_VALUE = 32'(pow10_minus1(NUM_DIGITS));
  localparam int BLINK_W = $clog2(BLINK_CYCLES + 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

  logic                    conv_busy;
  logic                    conv_done;
  logic [4*NUM_DIGITS-1:0] display_bcd;
  logic                    overflow_next;
  logic                    overflow_q;
  logic                    overflow_show;
  logic [BLINK_W-1:0]      blink_cnt;
  logic                    blink_off;
  logic [3:0]              digit;
  logic                    upper_zero;
  logic [6:0]              hex [6];

  bin2bcd_seq #(
    .BIN_WIDTH  (BIN_WIDTH),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (bus.load),
    .bin   (bus.value),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (display_bcd)
  );

  assign bus.busy = conv_busy;
  assign bus.done = conv_done;

  // overflow_next is judged when a load is accepted; it is committed on
  // the done pulse so that the flag changes together with the digits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_next <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      if (bus.load && !conv_busy) begin
        overflow_next <= (32'(bus.value) > MAX_VALUE);
      end
      if (conv_done) begin
        overflow_q <= overflow_next;
      end
    end
  end

  // During the done cycle overflow_q has not caught up yet, so the
  // pending value is forwarded to keep flag and display in step.
  assign overflow_show = conv_done ? overflow_next : overflow_q;
  assign bus.overflow  = overflow_show;

  // Blink phase: held in the visible phase while disabled, so enabling
  // always starts with a full visible half-period.
  always_ff @(posedge clk) begin
    if (!rst_n || !blink_en) begin
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      blink_off <= ~blink_off;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Walk from the most significant active digit down so upper_zero tells
  // whether this digit and everything above it are zero.
  always_comb begin
    hex        = '{default: SEG_BLANK};
    digit      = '0;
    upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      digit      = display_bcd[4*i +: 4];
      upper_zero = upper_zero && (digit == 4'd0);
      if (overflow_show) begin
        hex[i] = SEG_DASH;
      end else if (blank_lz && upper_zero && (i != 0)) begin
        hex[i] = SEG_BLANK;
      end else begin
        hex[i] = seg_decode(digit);
      end
    end
    if (blink_en && blink_off) begin
      hex = '{default: SEG_BLANK};
    end
  end

  assign HEX0 = hex[0];
  assign HEX1 = hex[1];
  assign HEX2 = hex[2];
  assign HEX3 = hex[3];
  assign HEX4 = hex[4];
  assign HEX5 = hex[5];

endmodule

// File: doc/score_display.md
# score_display

Sequential successor to the combinational hex decoder: takes an unsigned binary score, converts it to BCD with a multi-cycle shift-and-add-3 engine, and drives up to six active-low 7-segment digits. Adds leading-zero blanking, overflow indication and a blink mode. Sits between the game-logic score counter and the board HEX pins.

## Interface
- NUM_DIGITS, 3, active digits (1..6); HEX outputs above NUM_DIGITS-1 are always blank.
- BIN_WIDTH, 10, width of the binary input value (1..20).
- BLINK_CYCLES, 25_000_000, clock cycles per blink half-period (>=1).
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- value  in  BIN_WIDTH  unsigned binary score; sampled only when a load is accepted.
- load  in  1  conversion request; accepted only in IDLE.
- blank_lz  in  1  1 = blank leading zeros (HEX0 never blanked).
- blink_en  in  1  1 = blink all active digits.
- busy  out  1  1 while a conversion is in progress (CONV or DONE).
- done  out  1  one-cycle pulse when the new display value takes effect.
- overflow  out  1  latched: last accepted value > 10^NUM_DIGITS-1.
- HEX0..HEX5  out  7 each  active-low segments, bit 6 = g ... bit 0 = a.

## Operation
- FSM states: IDLE, CONV, DONE.
- IDLE: load=1 → capture value into shift reg, clear BCD scratch reg and bit counter, compute overflow_next = (value > MAX), go CONV.
- CONV: each cycle: every BCD nibble >= 5 gets +3, then {bcd,shift} shifts left by 1; counter increments; after BIN_WIDTH CONV cycles go DONE.
- BCD scratch width 4*NUM_DIGITS; bits shifted beyond it are discarded (overflow covers that case).
- DONE: copy scratch into display reg, overflow <= overflow_next, done=1, go IDLE.
- load while busy: ignored, no queuing; value changes during CONV have no effect.
- Display decode (combinational from display reg): digit i in 0..NUM_DIGITS-1 uses the standard 0-9 pattern; HEX digits >= NUM_DIGITS = 7'h7F.
- overflow=1: all active digits show dash 7'b0111111, blank_lz ignored.
- blank_lz=1: digit i (i>=1) blank when it and all higher active digits are 0.
- Blink: phase counter counts 0..BLINK_CYCLES-1, toggles blink_off at wrap; blink_off=1 forces all HEX to 7'h7F. blink_en=0 holds counter at 0 and blink_off=0 (next enable starts visible phase).

## Timing
- Reset (rst_n=0 at an edge): state IDLE, busy=0, done=0, overflow=0, display reg=0, blink counter 0, blink_off=0. Thus HEX0=7'b1000000; HEX1..NUM_DIGITS-1 = 7'b1000000 (blank_lz=0) or 7'h7F (blank_lz=1).
- Reset mid-conversion: aborts; display keeps reset value 0, no done pulse.
- Load accepted at edge E0: busy=1 after E0; CONV occupies E1..E(BIN_WIDTH); DONE after E(BIN_WIDTH): done=1 and new HEX visible in the same cycle, after E(BIN_WIDTH+1).
- busy falls after E(BIN_WIDTH+1); next load accepted at E(BIN_WIDTH+2) earliest (load held high reconverts back-to-back).
- blank_lz / blink_en changes affect HEX combinationally/next edge, independent of FSM.

## Structure
- Package display_pkg: seg constants SEG_BLANK (7'h7F), SEG_DASH (7'b0111111), digit pattern function seg_decode(logic [3:0]), function pow10_minus1(int n) for MAX.
- Sub-module bin2bcd_seq (FSM + shift/add-3 datapath, ports clk, rst_n, start, bin, busy, done, bcd); top adds overflow, blanking, blink and decode.

## Test plan
NUM_DIGITS=3, BIN_WIDTH=10, BLINK_CYCLES=4 unless noted.
- Reset then idle → HEX0=7'b1000000, busy=0, done=0, overflow=0; HEX3..HEX5=7'h7F.
- load value=255, blank_lz=0 → done exactly 11 edges after load edge; HEX2=7'b0100100, HEX1=7'b0010010, HEX0=7'b0010010.
- value=7, blank_lz=1 → HEX2=HEX1=7'h7F, HEX0=7'b1111000; value=0 → HEX0=7'b1000000 only.
- value=1000 → overflow=1, HEX2..HEX0=7'b0111111; then value=999 → overflow=0, all digits 7'b0010000.
- load=1 with value=42 mid-CONV of 123 → single done, display 123; rst_n=0 mid-CONV → no done, display 0.
- blink_en=1 after 255 shown → HEX visible 4 cycles, 7'h7F 4 cycles, repeating; blink_en=0 → visible immediately.
